// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO sequencer: op codes, FSM states, default iteration counts.
package hilo_pkg;
  localparam logic [1:0] OP_MULT = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 33;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;
endpackage

// File: rtl/hilo_sequencer.sv
// Sequences the iterative mult/div unit and holds architectural HI/LO.
// Optional HILO_BYPASS_EN: rd_data forwards same-cycle writes and CAPTURE results.
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       md_ctrl,
  output logic             md_rst,
  input  logic [WIDTH-1:0] md_hi,
  input  logic [WIDTH-1:0] md_lo,
  input  logic             md_divzero
);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [5:0]       r_cnt, w_cnt_nxt;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_busy, w_done, w_capture, w_set_dz, w_clr_dz, w_last;
  logic [1:0]       w_md_ctrl;
  logic [5:0]       w_n_m1;
  logic             w_wr_hi, w_wr_lo;
  logic [WIDTH-1:0] w_hi_view, w_lo_view;

  assign w_n_m1 = (r_op == OP_DIV) ? 6'(DIV_CYCLES - 1) : 6'(MULT_CYCLES - 1);
  assign w_last = (r_cnt == w_n_m1);

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_capture   = 1'b0;
    w_set_dz    = 1'b0;
    w_clr_dz    = 1'b0;
    w_md_ctrl   = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (start && (op == OP_MULT || op == OP_DIV)) begin
          w_state_nxt = S_CLEAR;
          w_op_nxt    = op;
          w_cnt_nxt   = 6'd0;
          w_clr_dz    = 1'b1;
        end
      end
      S_CLEAR: begin
        w_busy      = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy    = 1'b1;
        w_md_ctrl = r_op;
        w_cnt_nxt = r_cnt + 6'd1;
        // A divide-by-zero ends the op early and leaves HI/LO untouched.
        if (r_op == OP_DIV && md_divzero) begin
          w_state_nxt = S_DONE;
          w_set_dz    = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_busy      = 1'b1;
        w_capture   = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 2'd0;
      r_cnt      <= 6'd0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_clr_dz)      r_div_zero <= 1'b0;
      else if (w_set_dz) r_div_zero <= 1'b1;
    end
  end

  assign w_wr_hi = wr_hi & ~w_busy;
  assign w_wr_lo = wr_lo & ~w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_capture) begin
      r_hi <= md_hi;
      r_lo <= md_lo;
    end else begin
      if (w_wr_hi) r_hi <= wr_data;
      if (w_wr_lo) r_lo <= wr_data;
    end
  end

`ifdef HILO_BYPASS_EN
  always_comb begin
    w_hi_view = r_hi;
    w_lo_view = r_lo;
    if (w_capture) begin
      w_hi_view = md_hi;
      w_lo_view = md_lo;
    end else begin
      if (w_wr_hi) w_hi_view = wr_data;
      if (w_wr_lo) w_lo_view = wr_data;
    end
  end
`else
  assign w_hi_view = r_hi;
  assign w_lo_view = r_lo;
`endif

  assign rd_data  = rd_sel ? w_hi_view : w_lo_view;
  assign busy     = w_busy;
  assign done     = w_done;
  assign div_zero = r_div_zero;
  assign md_ctrl  = w_md_ctrl;
  assign md_rst   = reset | (r_state == S_CLEAR);

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer; the mult/div unit is a stub driven by bench variables.
module tb_hilo_sequencer;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        busy, done, div_zero, md_rst;
  logic [1:0]  md_ctrl;
  logic [31:0] md_hi = '0, md_lo = '0;
  logic        md_divzero = 1'b0;

  int n_chk = 0, n_err = 0;
  int cnt_mult = 0, cnt_div = 0, cnt_done = 0;
  int snap_done;
  int done_cyc, busy_cyc, d_mult, d_div;

  always #5 clk = ~clk;

  hilo_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .done(done), .div_zero(div_zero),
    .md_ctrl(md_ctrl), .md_rst(md_rst), .md_hi(md_hi), .md_lo(md_lo),
    .md_divzero(md_divzero)
  );

  // Count cycles the unit was driven with each op code, and done pulses.
  always @(posedge clk) begin
    if (md_ctrl == OP_MULT) cnt_mult <= cnt_mult + 1;
    if (md_ctrl == OP_DIV)  cnt_div  <= cnt_div + 1;
    if (done)               cnt_done <= cnt_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    rd_sel = 1'b1; #1;
    chk({tag, "_hi"}, rd_data, exp_hi);
    rd_sel = 1'b0; #1;
    chk({tag, "_lo"}, rd_data, exp_lo);
  endtask

  // Start an op at cycle 0 and follow it until done (bounded).
  task automatic run_op(input logic [1:0] o, input int dz_cyc, input int restart_cyc);
    int sm, sd;
    sm = cnt_mult; sd = cnt_div; snap_done = cnt_done;
    done_cyc = -1; busy_cyc = 0;
    next_cyc();
    start = 1'b1; op = o;
    next_cyc();
    for (int c = 1; c < 100; c++) begin
      if (c == dz_cyc) md_divzero = 1'b1;
      start = (c == restart_cyc);
      op    = (c == restart_cyc) ? OP_DIV : 2'd0;
      @(negedge clk);
      if (c == 1) begin
        chk("md_rst_c1", md_rst, 1);
        chk("dz_clr_c1", div_zero, 0);
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = c;
        break;
      end
      next_cyc();
    end
    md_divzero = 1'b0;
    d_mult = cnt_mult - sm;
    d_div  = cnt_div - sd;
  endtask

  task automatic after_done(input string tag);
    next_cyc();
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_done_pulses"}, cnt_done - snap_done, 1);
  endtask

  initial begin
    int sm;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_md_rst", md_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_ctrl", md_ctrl, 0);
    next_cyc();
    reset = 1'b0;
    rd("rst", 0, 0);
    chk("idle_md_rst", md_rst, 0);

    // MULT
    md_hi = 32'd0; md_lo = 32'd42;
    run_op(OP_MULT, -1, -1);
    chk("mult_done_cyc", done_cyc, 35);
    chk("mult_busy_cyc", busy_cyc, 34);
    chk("mult_ctrl", d_mult, 32);
    chk("mult_ctrl_div", d_div, 0);
    after_done("mult");
    rd("mult", 0, 42);

    // DIV
    md_hi = 32'd1; md_lo = 32'd3;
    run_op(OP_DIV, -1, -1);
    chk("div_done_cyc", done_cyc, 36);
    chk("div_busy_cyc", busy_cyc, 35);
    chk("div_ctrl", d_div, 33);
    after_done("div");
    rd("div", 1, 3);
    chk("div_dz", div_zero, 0);

    // DIV by zero: flag rises after the first RUN edge
    md_hi = 32'd77; md_lo = 32'd88;
    run_op(OP_DIV, 3, -1);
    chk("dz_done_cyc", done_cyc, 4);
    chk("dz_flag_done", div_zero, 1);
    chk("dz_ctrl", d_div, 2);
    after_done("dz");
    rd("dz_keep", 1, 3);
    chk("dz_flag_held", div_zero, 1);

    // following MULT clears div_zero (checked at cycle 1 in run_op)
    md_hi = 32'd0; md_lo = 32'd42;
    run_op(OP_MULT, -1, -1);
    chk("mult2_done_cyc", done_cyc, 35);
    after_done("mult2");
    rd("mult2", 0, 42);

    // op 0 / 3 are ignored
    next_cyc(); start = 1'b1; op = 2'd3;
    next_cyc(); op = 2'd0;
    @(negedge clk);
    chk("op3_busy", busy, 0);
    next_cyc(); start = 1'b0;
    @(negedge clk);
    chk("op0_busy", busy, 0);

    // MTHI in IDLE
    next_cyc();
    wr_hi = 1'b1; wr_data = 32'hDEADBEEF; rd_sel = 1'b1;
    @(negedge clk);
`ifdef HILO_BYPASS_EN
    chk("mthi_same", rd_data, 32'hDEADBEEF);
`else
    chk("mthi_same", rd_data, 32'd0);
`endif
    next_cyc();
    wr_hi = 1'b0;
    @(negedge clk);
    chk("mthi_next", rd_data, 32'hDEADBEEF);

    // MTHI+MTLO same cycle
    next_cyc();
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5A5A5A5A;
    next_cyc();
    wr_hi = 1'b0; wr_lo = 1'b0;
    rd("both", 32'h5A5A5A5A, 32'h5A5A5A5A);

    // MTLO while busy, then reset in the middle of RUN
    sm = cnt_mult;
    next_cyc(); start = 1'b1; op = OP_MULT;
    next_cyc(); start = 1'b0; op = 2'd0;
    for (int c = 2; c <= 5; c++) next_cyc();
    wr_lo = 1'b1; wr_data = 32'h00001234;
    next_cyc();
    wr_lo = 1'b0; rd_sel = 1'b0;
    @(negedge clk);
    chk("mtlo_busy", rd_data, 32'h5A5A5A5A);
    for (int c = 7; c <= 11; c++) next_cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_md_rst", md_rst, 1);
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ctrl", md_ctrl, 0);
    chk("abort_md_rst_low", md_rst, 0);
    chk("abort_ctrl_cnt", cnt_mult - sm, 10);
    rd("abort", 0, 0);

    // second start during RUN is ignored
    md_hi = 32'd5; md_lo = 32'd6;
    run_op(OP_MULT, -1, 5);
    chk("restart_done_cyc", done_cyc, 35);
    chk("restart_mult", d_mult, 32);
    chk("restart_div", d_div, 0);
    after_done("restart");
    rd("restart", 5, 6);
    repeat (3) next_cyc();
    chk("restart_no_extra", cnt_done - snap_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
